mul16_seq: RTL
==============

MUL16_SEQ -- requirements
Module: mul16_seq

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 16 bits.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request to begin a multiply; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, 16, multiplicand; sampled only on an accepted start.
REQ-006 The block SHALL have port b, input, 16, multiplier; sampled only on an accepted start.
REQ-007 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1, one-cycle pulse when product becomes valid.
REQ-009 The block SHALL have port product, output, 16, result a*b modulo 2^16; held until the next accepted start.

Function
REQ-010 The block SHALL implement states IDLE, RUN and DONE.
REQ-011 In IDLE with start=1, the block SHALL latch a into the multiplicand register, latch b into the multiplier register, clear the accumulator and bit counter, and enter RUN.
REQ-012 In RUN, each cycle SHALL process one multiplier bit, LSB first:
- accumulator <= accumulator + multiplicand if the current bit is 1, else unchanged
- multiplicand <= multiplicand shifted left 1, zero fill
- multiplier <= multiplier shifted right 1
- counter <= counter + 1
REQ-013 All additions SHALL be 16-bit and discard carry out (two's-complement wrap); signed and unsigned operands therefore yield identical low 16 bits.
REQ-014 RUN SHALL last exactly 16 cycles with no early termination; after the 16th bit the block SHALL enter DONE.
REQ-015 In DONE, the block SHALL drive done=1 for exactly one cycle, update product with the accumulator, and return to IDLE on the next edge.
REQ-016 Latency: start accepted at edge N SHALL give done=1 and valid product in the cycle after edge N+17.
REQ-017 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-018 start asserted in RUN or DONE SHALL be ignored: no restart, no re-sampling, and no queued request.
REQ-019 start held high continuously SHALL restart the operation from the IDLE cycle after each DONE. Back-to-back throughput SHALL be one result per 18 cycles.
REQ-020 product SHALL NOT change except in DONE or on reset; changes on a and b outside an accepted start SHALL have no effect.

Reset
REQ-021 reset=1 at a rising edge SHALL force state IDLE, busy=0, done=0, product=0x0000, and zero all internal registers, regardless of state.
REQ-022 reset SHALL take priority over start in the same cycle.
REQ-023 reset during RUN SHALL abandon the operation with no done pulse.
REQ-024 After reset deasserts, the block SHALL accept start in the first following cycle.

Structure
REQ-025 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the bit-count terminal value (15) SHALL reside in a shared include file, mul16_defs.vh, for reuse by bench and RTL.
REQ-026 The accumulator addition SHALL instantiate the existing Add16 module as the sole sub-module; no other adder logic is permitted.
REQ-027 The bit counter SHALL be 4 bits wide, and the RUN-exit condition SHALL be counter==15 while in RUN.

Verification
REQ-028 Bench: a=3, b=5, start pulsed one cycle -> busy rises next cycle, done pulses exactly 17 cycles after acceptance, product=0x000F.
REQ-029 Bench: a=0xFFFF, b=0xFFFF -> product=0x0001; a=0x0100, b=0x0100 -> product=0x0000 (wrap).
REQ-030 Bench: a=0xAAAA, b=0x0000, then a=0x0000, b=0x5555 -> product=0x0000 both times, latency still 17 cycles.
REQ-031 Bench: start with a=7, b=9; re-pulse start with a=2, b=2 mid-RUN -> single done, product=0x003F.
REQ-032 Bench: reset asserted 8 cycles into RUN -> no done, product=0x0000, busy=0; a new start with a=0x1234, b=0x0002 -> product=0x2468.
REQ-033 Bench: start held high for 40 cycles with a=2, b=3 -> done pulses 18 cycles apart, product=0x0006 each time.

Source files
------------

// File: rtl/mul16_seq_pkg.sv
// Package for the sequential multiplier: state type built on the shared encodings.
package mul16_seq_pkg;

`include "mul16_defs.vh"

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/mul16_defs.vh
// Shared encodings for the 16-bit sequential multiplier.
// Pulled into mul16_seq_pkg so the RTL and the bench see the same values.
`ifndef MUL16_DEFS_VH
`define MUL16_DEFS_VH

localparam logic [1:0] ST_IDLE  = 2'd0;
localparam logic [1:0] ST_RUN   = 2'd1;
localparam logic [1:0] ST_DONE  = 2'd2;
localparam logic [3:0] BIT_LAST = 4'd15;

`endif

// File: rtl/mul16_seq_add16.sv
// 16-bit adder used for accumulation; the carry out is dropped so results wrap mod 2^16.
module Add16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/mul16_seq.sv
// Shift-and-add 16x16 multiplier producing the low 16 bits of a*b.
// One multiplier bit per cycle, LSB first; 18 cycles per operation including IDLE.
module mul16_seq
    import mul16_seq_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    state_e      state_q;
    logic [15:0] multiplicand_q;
    logic [15:0] multiplier_q;
    logic [15:0] acc_q;
    logic [3:0]  count_q;
    logic [15:0] product_q;
    logic        busy_q;
    logic        done_q;

    logic [15:0] accSum;
    logic [15:0] acc_d;

    Add16 uAdd (
        .a_i   (acc_q),
        .b_i   (multiplicand_q),
        .sum_o (accSum)
    );

    assign acc_d = multiplier_q[0] ? accSum : acc_q;

    // done and busy are registered, so done appears in the cycle after DONE while busy has dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            multiplicand_q <= 16'h0000;
            multiplier_q   <= 16'h0000;
            acc_q          <= 16'h0000;
            count_q        <= 4'd0;
            product_q      <= 16'h0000;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        multiplicand_q <= a;
                        multiplier_q   <= b;
                        acc_q          <= 16'h0000;
                        count_q        <= 4'd0;
                        busy_q         <= 1'b1;
                        state_q        <= RUN;
                    end
                end
                RUN: begin
                    acc_q          <= acc_d;
                    multiplicand_q <= {multiplicand_q[14:0], 1'b0};
                    multiplier_q   <= {1'b0, multiplier_q[15:1]};
                    count_q        <= count_q + 4'd1;
                    if (count_q == BIT_LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q    <= 1'b1;
                    product_q <= acc_q;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
